armored_fec_mon: RTL and testbench
==================================

ARMORED_FEC_MON -- requirements
Module: armored_fec_mon

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent armored decoder lanes monitored (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each saturating statistics counter (8..32).
REQ-003 SHALL have parameter WINDOW_LOG2, default 10, log2 of the fail-rate window length in cycles (4..16).
REQ-004 SHALL have parameter FAIL_THRESH, default 4, fails per window that force a lane out of lock (1..15).
REQ-005 SHALL have parameter GOOD_TO_LOCK, default 64, consecutive fail-free valid words needed to lock (1..255).
REQ-006 SHALL have parameter TARGET_CHIP, default 0, device family selector, no functional effect.
REQ-007 SHALL have clk  input  1  rising-edge clock for all state; one clock only.
REQ-008 SHALL have aclr_n  input  1  reset, asynchronous assert, active-low.
REQ-009 SHALL have din_valid  input  LANES  per-lane strobe: decoder word present this cycle.
REQ-010 SHALL have din_fix  input  LANES  per-lane decoder corrected-error flag, qualified by din_valid.
REQ-011 SHALL have din_fail  input  LANES  per-lane decoder uncorrectable flag, qualified by din_valid.
REQ-012 SHALL have clr_stats  input  1  synchronous clear of all fix/fail counters.
REQ-013 SHALL have lane_locked  output  LANES  per-lane lock state.
REQ-014 SHALL have all_locked  output  1  AND of lane_locked.
REQ-015 SHALL have lock_lost  output  LANES  one-cycle pulse on LOCKED->HUNT transition.
REQ-016 SHALL have fix_cnt  output  LANES*CNT_WIDTH  packed, lane 0 in LSBs, saturating fix counts.
REQ-017 SHALL have fail_cnt  output  LANES*CNT_WIDTH  packed, lane 0 in LSBs, saturating fail counts.

Function
REQ-018 SHALL ignore din_fix/din_fail on any lane whose din_valid is 0.
REQ-019 SHALL treat din_fix and din_fail both high as a fail only (fix counter unchanged).
REQ-020 SHALL register all outputs; an input event in cycle N is reflected in outputs at cycle N+1.
REQ-021 SHALL run per lane a 2-state FSM, HUNT and LOCKED, with HUNT after reset.
REQ-022 SHALL in HUNT increment a good-run counter on each valid non-fail word, clear it on a valid fail, hold it on invalid cycles.
REQ-023 SHALL move HUNT->LOCKED in the cycle the good-run count reaches GOOD_TO_LOCK, then clear the good-run counter.
REQ-024 SHALL keep a single free-running window counter of WINDOW_LOG2 bits shared by all lanes, wrapping 2^WINDOW_LOG2-1 -> 0.
REQ-025 SHALL keep per lane a window fail counter (4 bits, saturating at 15) cleared on window wrap.
REQ-026 SHALL, when a fail coincides with the wrap cycle, count it into the new window (count becomes 1).
REQ-027 SHALL move LOCKED->HUNT in the cycle the window fail count reaches FAIL_THRESH, pulsing lock_lost for that lane for exactly one cycle.
REQ-028 SHALL clear the lane window fail counter on LOCKED->HUNT.
REQ-029 SHALL increment fix_cnt/fail_cnt by 1 per qualifying event and hold at 2^CNT_WIDTH-1 without wrap.
REQ-030 SHALL on clr_stats zero all fix_cnt and fail_cnt next cycle; clear wins over a coincident event (event lost); lock FSMs unaffected.

Reset
REQ-031 SHALL on aclr_n low asynchronously force: all FSMs HUNT, lane_locked 0, all_locked 0, lock_lost 0, fix_cnt 0, fail_cnt 0, window, window-fail and good-run counters 0.
REQ-032 SHALL resume counting on the first rising clk after aclr_n deasserts; reset mid-lock drops lock immediately without lock_lost pulse.

Structure
REQ-033 SHALL place FSM state enum (HUNT, LOCKED) and window-fail counter width constant in shared package armored_pkg.
REQ-034 SHALL implement one lane (FSM, good-run, window-fail, two stat counters) as sub-module armored_fec_mon_lane, instantiated LANES times; window counter lives in the top.

Verification
REQ-035 SHALL verify lock acquire: LANES=4, all valid, no errors -> lane_locked=4'hF and all_locked=1 at cycle 65 after reset release.
REQ-036 SHALL verify threshold: locked lane 2, 4 fails in one window -> lane_locked[2]=0, lock_lost=4'b0100 for one cycle, fail_cnt lane 2 = 4.
REQ-037 SHALL verify window split: 3 fails before wrap, 1 fail on wrap cycle -> lane stays locked, window fail count 1.
REQ-038 SHALL verify saturation: CNT_WIDTH=8, 300 fixes on lane 0 -> fix_cnt lane 0 = 255; clr_stats coincident with fix -> 0.
REQ-039 SHALL verify fix+fail together and invalid qualifiers: din_fix=din_fail=1 valid -> fail_cnt+1, fix_cnt unchanged; din_valid=0 with din_fail=1 -> no change.
REQ-040 SHALL verify aclr_n asserted while locked -> all outputs 0 asynchronously, no lock_lost pulse, relock after 64 good words.

Source files
------------

// File: rtl/armored_pkg.sv
// rtl/armored_pkg.sv - shared types and constants for the armored FEC lock monitor
package armored_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lane_state_e;

    localparam int WFAIL_W = 4;
    localparam logic [WFAIL_W-1:0] WFAIL_MAX = '1;

    localparam int GOOD_W = 8;

endpackage

// File: rtl/armored_fec_mon_lane.sv
// rtl/armored_fec_mon_lane.sv - one lane: lock FSM, good-run, window-fail and stat counters
module armored_fec_mon_lane
    import armored_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter int FAIL_THRESH  = 4,
    parameter int GOOD_TO_LOCK = 64
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 valid_i,
    input  logic                 fix_i,
    input  logic                 fail_i,
    input  logic                 clr_stats_i,
    input  logic                 wrap_i,
    output logic                 locked_o,
    output logic                 locked_d_o,
    output logic                 lock_lost_o,
    output logic [CNT_WIDTH-1:0] fix_cnt_o,
    output logic [CNT_WIDTH-1:0] fail_cnt_o
);

    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(GOOD_TO_LOCK - 1);
    localparam logic [WFAIL_W-1:0] THRESH    = WFAIL_W'(FAIL_THRESH);

    lane_state_e          state_q, state_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [WFAIL_W-1:0]   wf_q, wf_d;
    logic                 lost_q, lost_d;
    logic [CNT_WIDTH-1:0] fix_q, fix_d;
    logic [CNT_WIDTH-1:0] fail_q, fail_d;

    logic                 fail_ev;
    logic                 fix_ev;
    logic [WFAIL_W-1:0]   wf_base;
    logic [WFAIL_W-1:0]   wf_inc;

    // Next-state for lock FSM and its counters; a fail on the wrap cycle lands in the new window
    always_comb begin
        fail_ev = valid_i & fail_i;
        fix_ev  = valid_i & fix_i & ~fail_i;
        wf_base = wrap_i ? '0 : wf_q;
        wf_inc  = (fail_ev && wf_base != WFAIL_MAX) ? wf_base + WFAIL_W'(1) : wf_base;
        state_d = state_q;
        good_d  = good_q;
        wf_d    = wf_inc;
        lost_d  = 1'b0;
        case (state_q)
            HUNT: begin
                if (fail_ev) begin
                    good_d = '0;
                end else if (valid_i) begin
                    if (good_q == GOOD_LAST) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (fail_ev && wf_inc >= THRESH) begin
                    state_d = HUNT;
                    lost_d  = 1'b1;
                    wf_d    = '0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Saturating statistics; clear beats a coincident event
    always_comb begin
        fix_d  = fix_q;
        fail_d = fail_q;
        if (clr_stats_i) begin
            fix_d  = '0;
            fail_d = '0;
        end else begin
            if (fix_ev && fix_q != '1)
                fix_d = fix_q + CNT_WIDTH'(1);
            if (fail_ev && fail_q != '1)
                fail_d = fail_q + CNT_WIDTH'(1);
        end
    end

    // Lane state registers
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= HUNT;
            good_q  <= '0;
            wf_q    <= '0;
            lost_q  <= 1'b0;
            fix_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            wf_q    <= wf_d;
            lost_q  <= lost_d;
            fix_q   <= fix_d;
            fail_q  <= fail_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign locked_d_o  = (state_d == LOCKED);
    assign lock_lost_o = lost_q;
    assign fix_cnt_o   = fix_q;
    assign fail_cnt_o  = fail_q;

endmodule

// File: rtl/armored_fec_mon.sv
// rtl/armored_fec_mon.sv - multi-lane armored decoder lock and error-statistics monitor
module armored_fec_mon
    import armored_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int WINDOW_LOG2  = 10,
    parameter int FAIL_THRESH  = 4,
    parameter int GOOD_TO_LOCK = 64,
    parameter int TARGET_CHIP  = 0
) (
    input  logic                       clk,
    input  logic                       aclr_n,
    input  logic [LANES-1:0]           din_valid,
    input  logic [LANES-1:0]           din_fix,
    input  logic [LANES-1:0]           din_fail,
    input  logic                       clr_stats,
    output logic [LANES-1:0]           lane_locked,
    output logic                       all_locked,
    output logic [LANES-1:0]           lock_lost,
    output logic [LANES*CNT_WIDTH-1:0] fix_cnt,
    output logic [LANES*CNT_WIDTH-1:0] fail_cnt
);

    logic [WINDOW_LOG2-1:0] win_q;
    logic                   wrap;
    logic                   all_locked_q;
    logic [LANES-1:0]       locked_nxt;
    logic                   unused_target_chip;

    assign unused_target_chip = (TARGET_CHIP != 0);
    assign wrap               = &win_q;

    // Shared free-running window counter; wraps naturally at all-ones
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            win_q <= '0;
        else
            win_q <= win_q + WINDOW_LOG2'(1);
    end

    // Registered AND of next-cycle lane lock so it lines up with lane_locked
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            all_locked_q <= 1'b0;
        else
            all_locked_q <= &locked_nxt;
    end

    assign all_locked = all_locked_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        armored_fec_mon_lane #(
            .CNT_WIDTH    (CNT_WIDTH),
            .FAIL_THRESH  (FAIL_THRESH),
            .GOOD_TO_LOCK (GOOD_TO_LOCK)
        ) u_lane (
            .clk         (clk),
            .aclr_n      (aclr_n),
            .valid_i     (din_valid[l]),
            .fix_i       (din_fix[l]),
            .fail_i      (din_fail[l]),
            .clr_stats_i (clr_stats),
            .wrap_i      (wrap),
            .locked_o    (lane_locked[l]),
            .locked_d_o  (locked_nxt[l]),
            .lock_lost_o (lock_lost[l]),
            .fix_cnt_o   (fix_cnt[l*CNT_WIDTH +: CNT_WIDTH]),
            .fail_cnt_o  (fail_cnt[l*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_armored_fec_mon.sv
// tb/tb_armored_fec_mon.sv - scoreboard bench for armored_fec_mon
module tb_armored_fec_mon;

    localparam int LANES = 4;
    localparam int CW    = 8;
    localparam int VW    = 4 + 1 + 4 + 2 * LANES * CW;

    logic                  clk;
    logic                  aclr_n;
    logic [LANES-1:0]      din_valid;
    logic [LANES-1:0]      din_fix;
    logic [LANES-1:0]      din_fail;
    logic                  clr_stats;
    logic [LANES-1:0]      lane_locked;
    logic                  all_locked;
    logic [LANES-1:0]      lock_lost;
    logic [LANES*CW-1:0]   fix_cnt;
    logic [LANES*CW-1:0]   fail_cnt;

    armored_fec_mon #(
        .LANES        (LANES),
        .CNT_WIDTH    (CW),
        .WINDOW_LOG2  (6),
        .FAIL_THRESH  (4),
        .GOOD_TO_LOCK (64),
        .TARGET_CHIP  (0)
    ) dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .din_valid   (din_valid),
        .din_fix     (din_fix),
        .din_fail    (din_fail),
        .clr_stats   (clr_stats),
        .lane_locked (lane_locked),
        .all_locked  (all_locked),
        .lock_lost   (lock_lost),
        .fix_cnt     (fix_cnt),
        .fail_cnt    (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [VW-1:0] vec;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    int               n_vec;
    int               n_bad;
    int               ecnt;
    logic [LANES-1:0] m_locked;
    logic [LANES-1:0] m_lost;
    logic [CW-1:0]    m_fix[LANES];
    logic [CW-1:0]    m_fail[LANES];

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + CW'(1);
    endfunction

    function automatic logic [VW-1:0] pack_exp();
        logic [LANES*CW-1:0] fx, fl;
        for (int l = 0; l < LANES; l++) begin
            fx[l*CW +: CW] = m_fix[l];
            fl[l*CW +: CW] = m_fail[l];
        end
        return {m_locked, &m_locked, m_lost, fx, fl};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {lane_locked, all_locked, lock_lost, fix_cnt, fail_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic drive(input logic [LANES-1:0] v, input logic [LANES-1:0] fx,
                         input logic [LANES-1:0] fl, input logic c);
        din_valid = v;
        din_fix   = fx;
        din_fail  = fl;
        clr_stats = c;
        for (int l = 0; l < LANES; l++) begin
            if (c) begin
                m_fix[l]  = '0;
                m_fail[l] = '0;
            end else if (v[l]) begin
                if (fl[l])      m_fail[l] = sat_inc(m_fail[l]);
                else if (fx[l]) m_fix[l]  = sat_inc(m_fix[l]);
            end
        end
    endtask

    task automatic model_reset();
        m_locked = '0;
        m_lost   = '0;
        for (int l = 0; l < LANES; l++) begin
            m_fix[l]  = '0;
            m_fail[l] = '0;
        end
    endtask

    task automatic test_reset();
        model_reset();
        exp_q.push_back('{"reset_state", pack_exp()});
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        repeat (2) @(posedge clk);
        #1;
        aclr_n = 1'b1;
        ecnt   = 0;
    endtask

    task automatic test_lock_acquire(input string tag);
        for (int i = 0; i < 63; i++) begin
            drive('1, '0, '0, 1'b0);
            step();
        end
        exp_q.push_back('{{tag, "_63"}, pack_exp()});
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        drive('1, '0, '0, 1'b0);
        m_locked = '1;
        exp_q.push_back('{{tag, "_64"}, pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
    endtask

    task automatic test_threshold();
        for (int k = 1; k <= 4; k++) begin
            drive('1, '0, 4'b0100, 1'b0);
            if (k == 4) begin
                m_locked = 4'b1011;
                m_lost   = 4'b0100;
            end
            exp_q.push_back('{$sformatf("thresh_fail%0d", k), pack_exp()});
            step();
            e = exp_q.pop_front();
            n_vec++;
            if (obs() !== e.vec) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
            end
        end
        drive('0, '0, '0, 1'b0);
        m_lost = '0;
        exp_q.push_back('{"thresh_pulse_end", pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        for (int i = 0; i < 64; i++) begin
            drive('1, '0, '0, 1'b0);
            if (i == 63) begin
                m_locked = '1;
                exp_q.push_back('{"thresh_relock", pack_exp()});
            end
            step();
        end
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
    endtask

    task automatic test_window_split();
        int wrap_edge;
        wrap_edge = ((ecnt + 8) / 64 + 1) * 64;
        while (ecnt < wrap_edge - 4) begin
            drive('0, '0, '0, 1'b0);
            step();
        end
        for (int k = 1; k <= 7; k++) begin
            drive(4'b0010, '0, 4'b0010, 1'b0);
            if (k == 7) begin
                m_locked = 4'b1101;
                m_lost   = 4'b0010;
            end
            if (k == 4 || k == 6 || k == 7)
                exp_q.push_back('{$sformatf("split_fail%0d", k), pack_exp()});
            step();
            if (k == 4 || k == 6 || k == 7) begin
                e = exp_q.pop_front();
                n_vec++;
                if (obs() !== e.vec) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
                end
            end
        end
        drive('0, '0, '0, 1'b0);
        m_lost = '0;
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            drive(4'b0001, 4'b0001, '0, 1'b0);
            step();
        end
        exp_q.push_back('{"sat_fix255", pack_exp()});
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec || m_fix[0] !== 8'd255) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        drive(4'b0001, 4'b0001, '0, 1'b1);
        exp_q.push_back('{"sat_clr_wins", pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        drive(4'b0001, 4'b0001, '0, 1'b0);
        exp_q.push_back('{"sat_after_clr", pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
    endtask

    task automatic test_fix_fail_qual();
        drive(4'b1100, 4'b1100, 4'b1000, 1'b0);
        exp_q.push_back('{"fixfail_both", pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        drive(4'b0000, 4'b1111, 4'b1111, 1'b0);
        exp_q.push_back('{"invalid_ignored", pack_exp()});
        step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
    endtask

    task automatic test_reset_locked();
        drive('0, '0, '0, 1'b0);
        #3;
        aclr_n = 1'b0;
        model_reset();
        exp_q.push_back('{"async_reset", pack_exp()});
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        exp_q.push_back('{"reset_no_pulse", pack_exp()});
        repeat (2) step();
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e.vec) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs(), e.vec);
        end
        aclr_n = 1'b1;
        ecnt   = 0;
        test_lock_acquire("relock");
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        ecnt      = 0;
        aclr_n    = 1'b0;
        din_valid = '0;
        din_fix   = '0;
        din_fail  = '0;
        clr_stats = 1'b0;
        #2;
        test_reset();
        test_lock_acquire("lock");
        test_threshold();
        test_window_split();
        test_saturation();
        test_fix_fail_qual();
        test_reset_locked();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
